// File: rtl/id_ex_stage.sv
// id_ex_stage: decode stage and ID/EX pipeline register for the 16-bit, 8-register MIPS.
// Decodes control, bypasses writeback data, detects load-use hazards and counts stall cycles.
`default_nettype none

module id_ex_stage #(
    parameter int DW = 16,
    parameter int AW = 3,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          if_id_valid,
    input  logic [DW-1:0] if_id_instr,
    output logic [AW-1:0] ReadReg1,
    output logic [AW-1:0] ReadReg2,
    input  logic [DW-1:0] ReadData1,
    input  logic [DW-1:0] ReadData2,
    input  logic          wb_reg_write,
    input  logic [AW-1:0] wb_write_reg,
    input  logic [DW-1:0] wb_write_data,
    input  logic          flush,
    output logic          stall,
    output logic          ex_valid,
    output logic [DW-1:0] ex_rs_data,
    output logic [DW-1:0] ex_rt_data,
    output logic [DW-1:0] ex_imm,
    output logic [AW-1:0] ex_dest,
    output logic [2:0]    ex_funct,
    output logic          ex_reg_write,
    output logic          ex_mem_read,
    output logic          ex_mem_write,
    output logic          ex_alu_src,
    output logic          ex_branch,
    output logic [CW-1:0] stall_count
);

    localparam logic [3:0] c_OP_RTYPE = 4'b0000;
    localparam logic [3:0] c_OP_ADDI  = 4'b0100;
    localparam logic [3:0] c_OP_LW    = 4'b1000;
    localparam logic [3:0] c_OP_SW    = 4'b1010;
    localparam logic [3:0] c_OP_BEQ   = 4'b1100;

    logic [3:0]    opcode;
    logic [AW-1:0] rs, rt, rd;
    logic          dec_reg_write, dec_mem_read, dec_mem_write, dec_alu_src, dec_branch;
    logic          use_rs, use_rt;
    logic [AW-1:0] dec_dest;
    logic [DW-1:0] rs_data, rt_data;
    logic          hazard;

    logic          ex_valid_q, ex_reg_write_q, ex_mem_read_q, ex_mem_write_q;
    logic          ex_alu_src_q, ex_branch_q;
    logic [DW-1:0] ex_rs_data_q, ex_rt_data_q, ex_imm_q;
    logic [AW-1:0] ex_dest_q;
    logic [2:0]    ex_funct_q;
    logic [CW-1:0] stall_count_q, stall_count_d;

    assign opcode   = if_id_instr[15:12];
    assign rs       = if_id_instr[11:9];
    assign rt       = if_id_instr[8:6];
    assign rd       = if_id_instr[5:3];
    assign ReadReg1 = rs;
    assign ReadReg2 = rt;

    always_comb begin
        dec_reg_write = 1'b0;
        dec_mem_read  = 1'b0;
        dec_mem_write = 1'b0;
        dec_alu_src   = 1'b0;
        dec_branch    = 1'b0;
        use_rs        = 1'b0;
        use_rt        = 1'b0;
        dec_dest      = '0;
        case (opcode)
            c_OP_RTYPE: begin
                dec_reg_write = 1'b1;
                dec_dest      = rd;
                use_rs        = 1'b1;
                use_rt        = 1'b1;
            end
            c_OP_ADDI: begin
                dec_reg_write = 1'b1;
                dec_alu_src   = 1'b1;
                dec_dest      = rt;
                use_rs        = 1'b1;
            end
            c_OP_LW: begin
                dec_reg_write = 1'b1;
                dec_mem_read  = 1'b1;
                dec_alu_src   = 1'b1;
                dec_dest      = rt;
                use_rs        = 1'b1;
            end
            c_OP_SW: begin
                dec_mem_write = 1'b1;
                dec_alu_src   = 1'b1;
                use_rs        = 1'b1;
                use_rt        = 1'b1;
            end
            c_OP_BEQ: begin
                dec_branch    = 1'b1;
                use_rs        = 1'b1;
                use_rt        = 1'b1;
            end
            default: ;
        endcase
    end

    // Writeback bypass covers the register file's write-then-read in the same cycle.
    assign rs_data = (wb_reg_write && wb_write_reg == rs) ? wb_write_data : ReadData1;
    assign rt_data = (wb_reg_write && wb_write_reg == rt) ? wb_write_data : ReadData2;

    assign hazard = if_id_valid & ex_valid_q & ex_mem_read_q &
                    ((use_rs && ex_dest_q == rs) || (use_rt && ex_dest_q == rt));
    assign stall  = hazard & ~flush;

    assign stall_count_d = (stall && stall_count_q != {CW{1'b1}}) ?
                           stall_count_q + 1'b1 : stall_count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid_q     <= 1'b0;
            ex_reg_write_q <= 1'b0;
            ex_mem_read_q  <= 1'b0;
            ex_mem_write_q <= 1'b0;
            ex_alu_src_q   <= 1'b0;
            ex_branch_q    <= 1'b0;
            ex_rs_data_q   <= '0;
            ex_rt_data_q   <= '0;
            ex_imm_q       <= '0;
            ex_dest_q      <= '0;
            ex_funct_q     <= '0;
            stall_count_q  <= '0;
        end else begin
            stall_count_q  <= stall_count_d;
            // Data fields are captured unconditionally; they are ignored whenever the slot is a bubble.
            ex_rs_data_q   <= rs_data;
            ex_rt_data_q   <= rt_data;
            ex_imm_q       <= {{(DW-6){if_id_instr[5]}}, if_id_instr[5:0]};
            ex_dest_q      <= dec_dest;
            ex_funct_q     <= if_id_instr[2:0];
            if (flush || stall) begin
                ex_valid_q     <= 1'b0;
                ex_reg_write_q <= 1'b0;
                ex_mem_read_q  <= 1'b0;
                ex_mem_write_q <= 1'b0;
                ex_alu_src_q   <= 1'b0;
                ex_branch_q    <= 1'b0;
            end else begin
                ex_valid_q     <= if_id_valid;
                ex_reg_write_q <= if_id_valid & dec_reg_write;
                ex_mem_read_q  <= if_id_valid & dec_mem_read;
                ex_mem_write_q <= if_id_valid & dec_mem_write;
                ex_alu_src_q   <= if_id_valid & dec_alu_src;
                ex_branch_q    <= if_id_valid & dec_branch;
            end
        end
    end

    assign ex_valid     = ex_valid_q;
    assign ex_rs_data   = ex_rs_data_q;
    assign ex_rt_data   = ex_rt_data_q;
    assign ex_imm       = ex_imm_q;
    assign ex_dest      = ex_dest_q;
    assign ex_funct     = ex_funct_q;
    assign ex_reg_write = ex_reg_write_q;
    assign ex_mem_read  = ex_mem_read_q;
    assign ex_mem_write = ex_mem_write_q;
    assign ex_alu_src   = ex_alu_src_q;
    assign ex_branch    = ex_branch_q;
    assign stall_count  = stall_count_q;

endmodule

`default_nettype wire
